// File: rtl/arquitetura_fifo_writer.sv
// Avalon-MM slave that queues CPU writes and drains them into the shared FIFO write port.
// Also provides status, delivered-word count and drain-enable registers.
module arquitetura_fifo_writer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int LVL_W  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic              read,
  output logic [31:0]       readdata,
  input  logic              fifo_wrfull,
  output logic              fifo_wrreq,
  output logic [DATA_W-1:0] fifo_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_COUNT  = 2'd2,
    REG_CTRL   = 2'd3
  } reg_e;

  typedef struct packed {
    logic        wr;
    logic        rd;
    reg_e        addr;
    logic [31:0] wdata;
  } bus_req_t;

  bus_req_t          w_req;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_ovf;
  logic              r_en;
  logic [31:0]       r_count;

  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push_req;
  logic              w_accept;
  logic              w_reject;
  logic              w_sts_clr;
  logic              w_cnt_clr;
  logic              w_ctl_wr;
  logic [31:0]       w_status;

  assign w_req.wr    = chipselect & write;
  assign w_req.rd    = chipselect & read;
  assign w_req.addr  = reg_e'(address);
  assign w_req.wdata = writedata;

  assign w_full     = (r_level == LVL_W'(DEPTH));
  assign w_empty    = (r_level == '0);
  // Gated directly by wrfull so a request never overlaps the first full cycle.
  assign w_pop      = r_en & ~w_empty & ~fifo_wrfull;
  assign w_push_req = w_req.wr & (w_req.addr == REG_DATA);
  assign w_accept   = w_push_req & (~w_full | w_pop);
  assign w_reject   = w_push_req & ~w_accept;
  assign w_sts_clr  = w_req.wr & (w_req.addr == REG_STATUS) & w_req.wdata[3];
  assign w_cnt_clr  = w_req.wr & (w_req.addr == REG_COUNT);
  assign w_ctl_wr   = w_req.wr & (w_req.addr == REG_CTRL);

  assign fifo_wrreq = w_pop;
  assign fifo_data  = r_mem[r_rd_ptr];

  always_comb begin
    w_status             = '0;
    w_status[0]          = fifo_wrfull;
    w_status[1]          = w_full;
    w_status[2]          = w_empty;
    w_status[3]          = r_ovf;
    w_status[8 +: LVL_W] = r_level;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_accept) begin
      r_mem[r_wr_ptr] <= w_req.wdata[DATA_W-1:0];
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      case ({w_accept, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Set beats clear for overflow; clear beats increment for count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf   <= 1'b0;
      r_count <= '0;
      r_en    <= 1'b1;
    end else begin
      if (w_reject)       r_ovf <= 1'b1;
      else if (w_sts_clr) r_ovf <= 1'b0;
      if (w_cnt_clr)      r_count <= '0;
      else if (w_pop)     r_count <= r_count + 1'b1;
      if (w_ctl_wr)       r_en <= w_req.wdata[0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else if (w_req.rd) begin
      case (w_req.addr)
        REG_STATUS: readdata <= w_status;
        REG_COUNT:  readdata <= r_count;
        REG_CTRL:   readdata <= {31'd0, r_en};
        default:    readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_arquitetura_fifo_writer.sv
// Bench for arquitetura_fifo_writer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_arquitetura_fifo_writer;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int LVL_W  = 5;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [1:0]        address = '0;
  logic              chipselect = 1'b0;
  logic              write = 1'b0;
  logic [31:0]       writedata = '0;
  logic              read = 1'b0;
  logic [31:0]       readdata;
  logic              fifo_wrfull = 1'b0;
  logic              fifo_wrreq;
  logic [DATA_W-1:0] fifo_data;

  arquitetura_fifo_writer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .read(read), .readdata(readdata),
    .fifo_wrfull(fifo_wrfull), .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] mq[$];
  logic        m_ovf = 1'b0;
  logic        m_en  = 1'b1;
  logic [31:0] m_cnt = '0;
  logic        pend_v = 1'b0;
  logic [31:0] pend_d = '0;
  logic [31:0] sent[$];
  logic [31:0] exp_q[$];

  logic        e_pop, e_push, e_full, e_rej;
  logic [31:0] e_sts;

  // Model steps at the negedge, using the inputs the DUT will capture at the next posedge.
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      chk("rst_wrreq", {31'd0, fifo_wrreq}, 32'd0);
      chk("rst_readdata", readdata, 32'd0);
      mq.delete();
      m_ovf = 1'b0; m_en = 1'b1; m_cnt = '0; pend_v = 1'b0;
    end else begin
      e_pop = m_en && (mq.size() != 0) && !fifo_wrfull;
      chk("wrreq", {31'd0, fifo_wrreq}, {31'd0, e_pop});
      if (e_pop) chk("fifo_data", fifo_data, mq[0]);
      if (fifo_wrreq) sent.push_back(fifo_data);
      if (pend_v) chk("readdata", readdata, pend_d);
      pend_v = 1'b0;
      e_full = (mq.size() == DEPTH);
      if (chipselect && read) begin
        e_sts = '0;
        e_sts[0] = fifo_wrfull;
        e_sts[1] = e_full;
        e_sts[2] = (mq.size() == 0);
        e_sts[3] = m_ovf;
        e_sts[12:8] = 5'(mq.size());
        pend_v = 1'b1;
        case (address)
          2'd1:    pend_d = e_sts;
          2'd2:    pend_d = m_cnt;
          2'd3:    pend_d = {31'd0, m_en};
          default: pend_d = '0;
        endcase
      end
      e_push = chipselect && write && (address == 2'd0);
      e_rej  = 1'b0;
      if (e_pop) begin void'(mq.pop_front()); m_cnt = m_cnt + 1; end
      if (e_push) begin
        if (!e_full || e_pop) mq.push_back(writedata);
        else e_rej = 1'b1;
      end
      if (chipselect && write && address == 2'd1 && writedata[3]) m_ovf = 1'b0;
      if (e_rej) m_ovf = 1'b1;
      if (chipselect && write && address == 2'd2) m_cnt = '0;
      if (chipselect && write && address == 2'd3) m_en = writedata[0];
    end
  end

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic rd_chk(input string nm, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(a, d);
    chk(nm, d, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_sent(input string nm);
    chk({nm, "_len"}, sent.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < sent.size(); i++)
      chk(nm, sent[i], exp_q[i]);
    sent.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    #22 reset_n = 1'b1;
    @(posedge clk); #1;
    rd_chk("rst_status", 2'd1, 32'h0000_0004);
    rd_chk("rst_count", 2'd2, 32'd0);
    rd_chk("rst_ctrl", 2'd3, 32'd1);
    rd_chk("data_rd_zero", 2'd0, 32'd0);

    // Basic drain
    bus_wr(2'd0, 32'hA5);
    bus_wr(2'd0, 32'h5A);
    idle(3);
    exp_q = '{32'hA5, 32'h5A};
    chk_sent("basic_seq");
    rd_chk("basic_count", 2'd2, 32'd2);
    rd_chk("basic_status", 2'd1, 32'h0000_0004);

    // Backpressure and overflow
    fifo_wrfull = 1'b1;
    bus_wr(2'd2, 32'd0);
    for (int i = 1; i <= 5; i++) bus_wr(2'd0, 32'(i));
    chk("bp_no_wrreq", sent.size(), 32'd0);
    rd_chk("bp_status", 2'd1, 32'h0000_040B);
    fifo_wrfull = 1'b0;
    idle(6);
    exp_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    chk_sent("bp_seq");
    rd_chk("bp_count", 2'd2, 32'd4);
    bus_wr(2'd1, 32'h8);
    rd_chk("ovf_cleared", 2'd1, 32'h0000_0004);

    // Full queue with simultaneous pop and push
    fifo_wrfull = 1'b1;
    bus_wr(2'd0, 32'h11); bus_wr(2'd0, 32'h22);
    bus_wr(2'd0, 32'h33); bus_wr(2'd0, 32'h44);
    fifo_wrfull = 1'b0;
    bus_wr(2'd0, 32'h77);
    fifo_wrfull = 1'b1;
    rd_chk("fullpop_status", 2'd1, 32'h0000_0403);
    fifo_wrfull = 1'b0;
    idle(6);
    exp_q = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h77};
    chk_sent("fullpop_seq");

    // Enable control
    bus_wr(2'd3, 32'd0);
    bus_wr(2'd0, 32'hAA); bus_wr(2'd0, 32'hBB); bus_wr(2'd0, 32'hCC);
    rd_chk("dis_status", 2'd1, 32'h0000_0300);
    chk("dis_no_wrreq", sent.size(), 32'd0);
    rd_chk("dis_ctrl", 2'd3, 32'd0);
    bus_wr(2'd3, 32'd1);
    idle(5);
    exp_q = '{32'hAA, 32'hBB, 32'hCC};
    chk_sent("en_seq");
    rd_chk("en_ctrl", 2'd3, 32'd1);

    // Count clear coinciding with a pop
    bus_wr(2'd0, 32'hD1);
    bus_wr(2'd2, 32'd0);
    idle(2);
    rd_chk("cntclr_race", 2'd2, 32'd0);
    sent.delete();

    // Overflow stickiness and clearing
    fifo_wrfull = 1'b1;
    for (int i = 0; i < 5; i++) bus_wr(2'd0, 32'hE0 + 32'(i));
    rd_chk("ovf_set", 2'd1, 32'h0000_040B);
    bus_wr(2'd1, 32'h8);
    rd_chk("ovf_clr", 2'd1, 32'h0000_0403);
    bus_wr(2'd0, 32'hEE);
    rd_chk("ovf_again", 2'd1, 32'h0000_040B);

    // Async reset mid-drain
    fifo_wrfull = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("async_wrreq", {31'd0, fifo_wrreq}, 32'd0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    rd_chk("post_rst_status", 2'd1, 32'h0000_0004);
    rd_chk("post_rst_count", 2'd2, 32'd0);
    rd_chk("post_rst_ctrl", 2'd3, 32'd1);
    exp_q = '{32'hE0};
    chk_sent("pre_rst_seq");

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
